// File: rtl/mux2_1_2bit_arbiter_pkg.sv
// Shared constants and types for the 2-bit 2:1 mux and its upstream arbiter.
// The grant encoding doubles as the mux select value.
package mux2_1_2bit_arbiter_pkg;

    localparam int WIDTH = 2;

    typedef enum logic {
        PRIO_1 = 1'b0,
        PRIO_2 = 1'b1
    } prio_e;

    function automatic prio_e other_prio(input prio_e p);
        return (p == PRIO_1) ? PRIO_2 : PRIO_1;
    endfunction

endpackage

// File: rtl/mux2_1_2bit.sv
// 2:1 select of two WIDTH-bit words (selec=0 picks in1, selec=1 picks in2).
// Latency: combinational. Backpressure: none, pure datapath.
// Flow control is handled by the instantiating stage.
module mux2_1_2bit
    import mux2_1_2bit_arbiter_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         selec,
    output logic [W-1:0] out
);

    assign out = selec ? in2 : in1;

endmodule

// File: rtl/mux2_1_2bit_arbiter.sv
// Round-robin arbiter feeding mux2_1_2bit from two 1-entry slots into a registered output.
// Latency: input handshake at edge N -> out_valid after edge N+1 when the output stage is free.
// Backpressure: out_ready low freezes the output; a slot only accepts when empty or being granted.
module mux2_1_2bit_arbiter
    import mux2_1_2bit_arbiter_pkg::*;
#(
    parameter int   WIDTH     = mux2_1_2bit_arbiter_pkg::WIDTH,
    parameter logic INIT_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic [WIDTH-1:0] in2_data,
    output logic             in2_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             selec_2bit
);

    localparam prio_e PRIO_RST = prio_e'(INIT_PRIO);

    prio_e            prio_q;
    prio_e            prio_d;
    prio_e            sel;
    logic             sel_bit;
    logic             load;
    logic             grant1;
    logic             grant2;
    logic             hold1_vld;
    logic             hold2_vld;
    logic [WIDTH-1:0] hold1_dat;
    logic [WIDTH-1:0] hold2_dat;
    logic [WIDTH-1:0] mux_dat;

    // A lone occupied slot wins outright; prio only breaks ties.
    always_comb begin
        sel    = prio_q;
        prio_d = prio_q;
        if (hold1_vld && !hold2_vld) begin
            sel = PRIO_1;
        end else if (!hold1_vld && hold2_vld) begin
            sel = PRIO_2;
        end
        load   = (hold1_vld || hold2_vld) && (!out_valid || out_ready);
        grant1 = load && (sel == PRIO_1);
        grant2 = load && (sel == PRIO_2);
        if (load) begin
            prio_d = other_prio(sel);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= PRIO_RST;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign sel_bit    = (sel == PRIO_2);
    assign selec_2bit = sel_bit;
    assign in1_ready  = !hold1_vld || grant1;
    assign in2_ready  = !hold2_vld || grant2;

    mux2_1_2bit #(
        .W (WIDTH)
    ) u_mux (
        .in1   (hold1_dat),
        .in2   (hold2_dat),
        .selec (sel_bit),
        .out   (mux_dat)
    );

    // Refill takes precedence over clear so a granted slot can reload in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold1_vld <= 1'b0;
            hold1_dat <= '0;
            hold2_vld <= 1'b0;
            hold2_dat <= '0;
        end else begin
            if (in1_valid && in1_ready) begin
                hold1_vld <= 1'b1;
                hold1_dat <= in1_data;
            end else if (grant1) begin
                hold1_vld <= 1'b0;
            end
            if (in2_valid && in2_ready) begin
                hold2_vld <= 1'b1;
                hold2_dat <= in2_data;
            end else if (grant2) begin
                hold2_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mux_dat;
            out_src   <= sel_bit;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_1_2bit_arbiter.sv
// Directed and random stimulus for mux2_1_2bit_arbiter with per-channel scoreboards,
// an ordered expectation queue for directed sequences, and a round-robin fairness monitor.
module tb_mux2_1_2bit_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in1_valid;
    logic [1:0] in1_data;
    logic       in1_ready;
    logic       in2_valid;
    logic [1:0] in2_data;
    logic       in2_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_src;
    logic       out_ready;
    logic       selec_2bit;

    int total = 0;
    int bad   = 0;

    logic [1:0] q1[$];
    logic [1:0] q2[$];
    logic [2:0] exp_q[$];
    logic [1:0] s1[4];
    logic [1:0] s2[4];

    int occ1, occ2, skip1, skip2;
    bit pend1, pend2, lp;

    always #5 clk = ~clk;

    mux2_1_2bit_arbiter #(
        .WIDTH     (2),
        .INIT_PRIO (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in1_valid  (in1_valid),
        .in1_data   (in1_data),
        .in1_ready  (in1_ready),
        .in2_valid  (in2_valid),
        .in2_data   (in2_data),
        .in2_ready  (in2_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .selec_2bit (selec_2bit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, when inputs driven after the rising edge are stable.
    always @(negedge clk) begin
        if (reset) begin
            q1.delete();
            q2.delete();
            exp_q.delete();
            occ1 = 0; occ2 = 0; skip1 = 0; skip2 = 0;
            pend1 = 0; pend2 = 0; lp = 1;
        end else begin
            if (lp && out_valid) begin
                if (occ1 > 0 && occ2 > 0) begin
                    if (out_src) begin skip1++; skip2 = 0; end
                    else begin skip2++; skip1 = 0; end
                    check("fairness", (skip1 < 2) && (skip2 < 2), 1);
                end else if (out_src) skip2 = 0;
                else skip1 = 0;
                if (out_src) begin
                    check("load_from_empty_slot2", occ2 > 0, 1);
                    if (occ2 > 0) occ2--;
                end else begin
                    check("load_from_empty_slot1", occ1 > 0, 1);
                    if (occ1 > 0) occ1--;
                end
            end
            occ1 += int'(pend1);
            occ2 += int'(pend2);
            if (out_valid && out_ready) begin
                if (!out_src) begin
                    check("ch1_word_present", q1.size() > 0, 1);
                    if (q1.size() > 0) check("ch1_data", out_data, q1.pop_front());
                end else begin
                    check("ch2_word_present", q2.size() > 0, 1);
                    if (q2.size() > 0) check("ch2_data", out_data, q2.pop_front());
                end
                if (exp_q.size() > 0) check("ordered_output", {out_src, out_data}, exp_q.pop_front());
            end
            pend1 = in1_valid && in1_ready;
            pend2 = in2_valid && in2_ready;
            if (pend1) q1.push_back(in1_data);
            if (pend2) q2.push_back(in2_data);
            lp = !out_valid || out_ready;
        end
    end

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((q1.size() > 0 || q2.size() > 0 || exp_q.size() > 0 || out_valid) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_within_budget", c < budget, 1);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Streams s1[0..n1-1] / s2[0..n2-1]; out_ready held low for the first 'stall' cycles.
    task automatic stream(input int n1, input int n2, input int stall, input int budget);
        int i1 = 0;
        int i2 = 0;
        int c  = 0;
        bit h1, h2;
        while ((i1 < n1 || i2 < n2) && c < budget) begin
            in1_valid = (i1 < n1);
            in1_data  = (i1 < n1) ? s1[i1] : 2'b00;
            in2_valid = (i2 < n2);
            in2_data  = (i2 < n2) ? s2[i2] : 2'b00;
            out_ready = (c >= stall);
            @(negedge clk);
            if (stall > 0 && c >= 2 && c < stall) begin
                check("stall_out_data", out_data, 2'b10);
                check("stall_out_src", out_src, 1'b0);
            end
            if (stall > 0 && c == stall - 1) begin
                check("stall_in1_ready", in1_ready, 1'b0);
                check("stall_in2_ready", in2_ready, 1'b0);
                check("stall_out_valid", out_valid, 1'b1);
            end
            h1 = in1_valid && in1_ready;
            h2 = in2_valid && in2_ready;
            @(posedge clk); #1;
            if (h1) i1++;
            if (h2) i2++;
            c++;
        end
        check("stream_within_budget", c < budget, 1);
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        bit h1, h2;
        reset     = 1'b1;
        in1_valid = 1'b0; in1_data = 2'b00;
        in2_valid = 1'b0; in2_data = 2'b00;
        out_ready = 1'b0;

        // 1. reset and idle
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 2'b00);
        check("rst_in1_ready", in1_ready, 1'b1);
        check("rst_in2_ready", in2_ready, 1'b1);
        check("rst_selec", selec_2bit, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_in1_ready", in1_ready, 1'b1);
        check("idle_in2_ready", in2_ready, 1'b1);
        check("idle_selec", selec_2bit, 1'b0);

        // 2. single word from in1
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 2'b10});
        in1_valid = 1'b1; in1_data = 2'b10;
        @(posedge clk); #1;
        in1_valid = 1'b0;
        @(negedge clk);
        check("single_not_yet", out_valid, 1'b0);
        @(negedge clk);
        check("single_out_valid", out_valid, 1'b1);
        check("single_out_data", out_data, 2'b10);
        check("single_out_src", out_src, 1'b0);
        @(negedge clk);
        check("single_drained", out_valid, 1'b0);

        // 3. both saturated, alternating grants from a fresh prio
        reset_pulse();
        s1 = '{2'd0, 2'd1, 2'd2, 2'd3};
        s2 = '{2'd3, 2'd2, 2'd1, 2'd0};
        exp_q.push_back({1'b0, 2'd0}); exp_q.push_back({1'b1, 2'd3});
        exp_q.push_back({1'b0, 2'd1}); exp_q.push_back({1'b1, 2'd2});
        exp_q.push_back({1'b0, 2'd2}); exp_q.push_back({1'b1, 2'd1});
        exp_q.push_back({1'b0, 2'd3}); exp_q.push_back({1'b1, 2'd0});
        stream(4, 4, 0, 100);
        wait_drain(100);

        // 4. back-pressure for 5 cycles; in1 holds the tie-break after test 3
        s1 = '{2'd2, 2'd1, 2'd3, 2'd0};
        s2 = '{2'd0, 2'd3, 2'd1, 2'd0};
        exp_q.push_back({1'b0, 2'd2}); exp_q.push_back({1'b1, 2'd0});
        exp_q.push_back({1'b0, 2'd1}); exp_q.push_back({1'b1, 2'd3});
        exp_q.push_back({1'b0, 2'd3}); exp_q.push_back({1'b1, 2'd1});
        stream(3, 3, 5, 100);
        wait_drain(100);

        // 5. async reset with a stalled output word and a held slot
        out_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 2'b11;
        @(posedge clk); #1;
        in1_valid = 1'b0;
        in2_valid = 1'b1; in2_data = 2'b01;
        @(posedge clk); #1;
        in2_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", out_valid, 1'b1);
        check("pre_rst_out_data", out_data, 2'b11);
        check("pre_rst_selec", selec_2bit, 1'b1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_selec", selec_2bit, 1'b0);
        check("async_rst_in2_ready", in2_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 2'b10});
        in2_valid = 1'b1; in2_data = 2'b10;
        @(posedge clk); #1;
        in2_valid = 1'b0;
        wait_drain(50);

        // 6. random valid/ready
        h1 = 0; h2 = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!in1_valid || h1) begin
                in1_valid = 1'($urandom_range(0, 1));
                in1_data  = 2'($urandom_range(0, 3));
            end
            if (!in2_valid || h2) begin
                in2_valid = 1'($urandom_range(0, 1));
                in2_data  = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            h1 = in1_valid && in1_ready;
            h2 = in2_valid && in2_ready;
            @(posedge clk); #1;
        end
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
